// File: rtl/simon_pkg.sv
// Shared Simon game definitions: flasher state encoding, LED codes and round limit.
package simon_pkg;

  typedef enum logic [1:0] {
    FLASH_IDLE = 2'd0,
    FLASH_ON   = 2'd1,
    FLASH_OFF  = 2'd2,
    FLASH_DONE = 2'd3
  } flash_state_t;

  localparam logic [1:0] LED_LEFT  = 2'b10;
  localparam logic [1:0] LED_RIGHT = 2'b01;
  localparam logic [1:0] LED_DARK  = 2'b00;

  localparam int MAX_ROUND = 7;

  // A 1 bit lights the right LED, a 0 bit the left one.
  function automatic logic [1:0] led_for_bit(input logic b);
    return b ? LED_RIGHT : LED_LEFT;
  endfunction

endpackage

// File: rtl/interval_timer.sv
// Loadable down-counter: holds N after a load, expires on the cycle it reads 1,
// so a phase started by a load lasts exactly N cycles. Parks at 0 when idle.
module interval_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sequence_flasher.sv
// Replays bits 0..round of the Simon pattern on LEDs 5:4, then raises flash_done.
// Optional FLASH_SPEEDUP_EN halves the ON time for rounds with last index >= 4.
module sequence_flasher
  import simon_pkg::*;
#(
  parameter int ON_CYCLES  = 50_000_000,
  parameter int OFF_CYCLES = 25_000_000,
  parameter int CNT_W      = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flash_enable,
  input  logic [2:0] round,
  input  logic [7:0] bit_gen,
  output logic [1:0] led_flash,
  output logic       flash_done
);

  localparam logic [CNT_W-1:0] ON_FULL = CNT_W'(ON_CYCLES);
  localparam logic [CNT_W-1:0] OFF_VAL = CNT_W'(OFF_CYCLES);

  flash_state_t     state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       last_idx_q, last_idx_d;
  logic [7:0]       pat_q, pat_d;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_expired;
  logic [2:0]       run_last_idx;
  logic [CNT_W-1:0] on_val;

  // While idle the run has not latched yet, so the ON time follows the live round.
  assign run_last_idx = (state_q == FLASH_IDLE) ? round : last_idx_q;

`ifdef FLASH_SPEEDUP_EN
  localparam logic [CNT_W-1:0] ON_HALF = CNT_W'(ON_CYCLES >> 1);
  assign on_val = (run_last_idx >= 3'd4) ? ON_HALF : ON_FULL;
`else
  assign on_val = ON_FULL;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    pat_d      = pat_q;
    timer_load = 1'b0;
    timer_val  = on_val;
    unique case (state_q)
      FLASH_IDLE: begin
        if (flash_enable) begin
          last_idx_d = round;
          pat_d      = bit_gen;
          idx_d      = 3'd0;
          timer_load = 1'b1;
          timer_val  = on_val;
          state_d    = FLASH_ON;
        end
      end
      FLASH_ON: begin
        if (!flash_enable) begin
          state_d = FLASH_IDLE;
        end else if (timer_expired) begin
          timer_load = 1'b1;
          timer_val  = OFF_VAL;
          state_d    = FLASH_OFF;
        end
      end
      FLASH_OFF: begin
        if (!flash_enable) begin
          state_d = FLASH_IDLE;
        end else if (timer_expired) begin
          if (idx_q == last_idx_q) begin
            state_d = FLASH_DONE;
          end else begin
            idx_d      = idx_q + 3'd1;
            timer_load = 1'b1;
            timer_val  = on_val;
            state_d    = FLASH_ON;
          end
        end
      end
      FLASH_DONE: begin
        if (!flash_enable) begin
          state_d = FLASH_IDLE;
        end
      end
      default: state_d = FLASH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FLASH_IDLE;
      idx_q      <= 3'd0;
      last_idx_q <= 3'd0;
      pat_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      pat_q      <= pat_d;
    end
  end

  interval_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .load_val(timer_val),
    .expired (timer_expired)
  );

  // Outputs decode registered state only; inputs never reach the LEDs directly.
  assign led_flash  = (state_q == FLASH_ON) ? led_for_bit(pat_q[idx_q]) : LED_DARK;
  assign flash_done = (state_q == FLASH_DONE);

endmodule

// File: tb/tb_sequence_flasher.sv
// Randomized scoreboard bench for sequence_flasher: a trace-level model queues the
// expected {led_flash, flash_done} per cycle and a monitor compares on negedges.
module tb_sequence_flasher;

  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int CW  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       flash_enable;
  logic [2:0] round;
  logic [7:0] bit_gen;
  logic [1:0] led_flash;
  logic       flash_done;

  always #5 clk = ~clk;

  sequence_flasher #(
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flash_enable(flash_enable),
    .round       (round),
    .bit_gen     (bit_gen),
    .led_flash   (led_flash),
    .flash_done  (flash_done)
  );

  typedef struct packed {
    logic [1:0] led;
    logic       done;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] trace_q[$];
  int         mode = 0;   // 0 idle, 1 playing, 2 finished
  int         checks = 0;
  int         failures = 0;

  function automatic int t_on(input logic [2:0] r);
`ifdef FLASH_SPEEDUP_EN
    return (r >= 3'd4) ? ON / 2 : ON;
`else
    return ON;
`endif
  endfunction

  // Edges with enable high needed to play a whole run and then sit in DONE.
  function automatic int full_edges(input logic [2:0] r, input int hold);
    return (int'(r) + 1) * (t_on(r) + OFF) + 1 + hold;
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Drive one edge's inputs, then advance the model by that edge and queue the result.
  task automatic step(input logic rst, input logic en, input logic [2:0] r, input logic [7:0] p);
    exp_t e;
    reset        = rst;
    flash_enable = en;
    round        = r;
    bit_gen      = p;
    @(posedge clk);
    #1;
    e = '{led: 2'b00, done: 1'b0};
    if (rst) begin
      mode = 0;
      trace_q.delete();
    end else begin
      case (mode)
        0: if (en) begin
          for (int i = 0; i <= int'(r); i++) begin
            repeat (t_on(r)) trace_q.push_back(p[i] ? 2'b01 : 2'b10);
            repeat (OFF) trace_q.push_back(2'b00);
          end
          mode  = 1;
          e.led = trace_q.pop_front();
        end
        1: if (!en) begin
          mode = 0;
          trace_q.delete();
        end else if (trace_q.size() == 0) begin
          mode   = 2;
          e.done = 1'b1;
        end else begin
          e.led = trace_q.pop_front();
        end
        default: if (!en) mode = 0; else e.done = 1'b1;
      endcase
    end
    exp_q.push_back(e);
  endtask

  // Start a run, keep enable high for high_edges edges, then two idle edges.
  task automatic run(input logic [2:0] r, input logic [7:0] p, input int high_edges, input bit scramble);
    logic [2:0] rr;
    logic [7:0] pp;
    step(1'b0, 1'b1, r, p);
    for (int k = 1; k < high_edges; k++) begin
      rr = scramble ? 3'($urandom) : r;
      pp = scramble ? 8'($urandom) : p;
      step(1'b0, 1'b1, rr, pp);
    end
    step(1'b0, 1'b0, 3'($urandom), 8'($urandom));
    step(1'b0, 1'b0, 3'($urandom), 8'($urandom));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("led_flash", led_flash, e.led);
      check("flash_done", {1'b0, flash_done}, {1'b0, e.done});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] r;
    logic [7:0] p;
    int         len;

    reset = 1'b1; flash_enable = 1'b0; round = 3'd0; bit_gen = 8'h00;
    step(1'b1, 1'b0, 3'd0, 8'h00);
    step(1'b1, 1'b1, 3'd7, 8'hFF);          // reset beats enable
    step(1'b0, 1'b0, 3'd0, 8'h00);

    run(3'd0, 8'h01, full_edges(3'd0, 2), 1'b0);   // single bit
    run(3'd7, 8'hA5, full_edges(3'd7, 3), 1'b0);   // full pattern
    run(3'd7, 8'($urandom), 13, 1'b0);             // abort around bit 2
    run(3'd2, 8'($urandom), full_edges(3'd2, 1), 1'b0);
    run(3'd3, 8'hFF, full_edges(3'd3, 0), 1'b1);   // inputs churn mid-run
    run(3'd4, 8'($urandom), full_edges(3'd4, 1), 1'b0);

    // Reset while lit
    step(1'b0, 1'b1, 3'd5, 8'h3C);
    step(1'b0, 1'b1, 3'd5, 8'h3C);
    step(1'b1, 1'b1, 3'd5, 8'h3C);
    step(1'b0, 1'b0, 3'd5, 8'h3C);

    for (int n = 0; n < 12; n++) begin
      r   = 3'($urandom_range(0, 7));
      p   = 8'($urandom);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, full_edges(r, 0) - 1)
                                         : full_edges(r, $urandom_range(0, 3));
      run(r, p, len, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 2'(exp_q.size() > 0 ? 1 : 0), 2'b00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequence_flasher.md
# sequence_flasher

Plays the stored Simon bit pattern on two LEDs, one bit at a time, for bits 0 through `round`. It sits directly downstream of the game controller. The controller raises `flash_enable` with the current `round` and pattern. This block replays the pattern and raises `flash_done`, which tells the controller to start collecting button input. The `led_flash` output drives board LEDs 5:4.

## Interface
Parameters:
- `ON_CYCLES`, default 50_000_000: LED lit time per bit (0.5 s at 100 MHz); must be ≥ 2.
- `OFF_CYCLES`, default 25_000_000: blank gap after each bit; must be ≥ 1.
- `CNT_W`, default 26: interval counter width; must satisfy 2^CNT_W > max(ON_CYCLES, OFF_CYCLES).

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system clock, 100 MHz.
- `reset` input 1: synchronous, active-high; forces IDLE.
- `flash_enable` input 1: level request from the controller; high means play, low means abort or idle.
- `round` input 3: index of the last bit to play, so `round + 1` bits are played.
- `bit_gen` input 8: pattern; bit i is played i-th.
- `led_flash` output 2: [1] is the left LED (shows a 0 bit); [0] is the right LED (shows a 1 bit).
- `flash_done` output 1: level; high in DONE.

## Operation
States:
- IDLE: outputs 0. When `flash_enable` = 1, latch `round` into `last_idx` and `bit_gen` into `pat`, clear `idx`, load the timer with ON_CYCLES, and go to ON.
- ON: drive `led_flash` = `pat[idx]` ? 2'b01 : 2'b10. When the timer expires, load OFF_CYCLES and go to OFF.
- OFF: `led_flash` = 0. When the timer expires:
  - if `idx == last_idx`, go to DONE;
  - otherwise increment `idx`, load the ON time, and go to ON.
- DONE: `flash_done` = 1 and `led_flash` = 0. Stay until `flash_enable` = 0, then go to IDLE.

Rules:
- `flash_enable` = 0 in ON or OFF aborts to IDLE at the next edge. No `flash_done` is produced on abort.
- `round` and `bit_gen` are sampled only on the IDLE→ON transition. Later changes have no effect until the next start.
- `idx` and `last_idx` are 3 bits. `round` = 7 plays all 8 bits, and `idx` never wraps.
- Exactly one LED is lit in ON, and both are dark in every other state. `led_flash` = 2'b11 never occurs.
- The timer loads N and counts down to 1. Expiry is the cycle the count equals 1, so each phase lasts exactly N cycles.

## Timing
- Reset values: state = IDLE, `led_flash` = 2'b00, `flash_done` = 0, `idx` = 0, timer = 0. Reset has priority over all other inputs in any state.
- `led_flash` and `flash_done` are decoded from registers only, with no combinational path from the inputs.
- Start latency: `flash_enable` sampled high at edge E0 puts the first bit on `led_flash` in the cycle after E0.
- `flash_done` rises at edge E0 + (round+1)·(T_on + OFF_CYCLES), where T_on is the ON time.
- `flash_done` falls one edge after `flash_enable` is sampled low.
- Restart: at least one IDLE cycle is required between runs. Keeping `flash_enable` high holds DONE and does not replay.

## Configuration
- `FLASH_SPEEDUP_EN` defined: T_on = ON_CYCLES >> 1 when `last_idx` ≥ 4, otherwise ON_CYCLES. The later rounds play faster. OFF time is unchanged.
- `FLASH_SPEEDUP_EN` undefined: T_on = ON_CYCLES always.
- The macro is decoded at a single point, the ON-load mux.

## Structure
- Package `simon_pkg` holds:
  - the state enum `flash_state_t` (IDLE, ON, OFF, DONE);
  - `LED_LEFT` = 2'b10 and `LED_RIGHT` = 2'b01;
  - `MAX_ROUND` = 7, shared with the game controller.
- One sub-module, `interval_timer`: a loadable down-counter with `load` and `load_val[CNT_W-1:0]` inputs and an `expired` output. Used by this block; a later response timer can reuse it.

## Test plan
All scenarios use ON_CYCLES = 4 and OFF_CYCLES = 2.
- Reset mid-sequence: assert `reset` during ON → next cycle `led_flash` = 00, `flash_done` = 0, state IDLE.
- Single bit: `round` = 0, `bit_gen` = 8'h01, enable at E0 → `led_flash` = 01 for 4 cycles, then 00 for 2 cycles; `flash_done` = 1 at E0+6.
- Full pattern: `round` = 7, `bit_gen` = 8'hA5 → LED sequence R,L,R,L,L,R,L,R, with 01/10 alternating with 00 gaps; `flash_done` at E0+48.
- Abort: drop `flash_enable` during bit 2 → outputs 00 next cycle and no `flash_done`. Re-enable → playback restarts from bit 0 with newly sampled inputs.
- Input change: change `bit_gen` from 8'hFF to 8'h00 mid-run → the played bits stay 01 throughout.
- `FLASH_SPEEDUP_EN`: `round` = 4 → each ON phase lasts 2 cycles and `flash_done` at E0+20. With the macro undefined, `flash_done` at E0+30.
